// File: rtl/fft_mag_peak.sv
`default_nettype none
// ============================================================================
// Module   : fft_mag_peak
// Purpose  : Per-bin L1 magnitude (|re|+|im|) of an FFT output stream with
//            bin index, plus per-frame peak search with frame_done /
//            frame_err pulses.
// Revision : 1.0 - initial release
// ============================================================================
module fft_mag_peak #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 1024,
  parameter int IDX_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              source_valid,
  input  logic [DATA_W-1:0] source_real,
  input  logic [DATA_W-1:0] source_imag,
  output logic              mag_valid,
  output logic [DATA_W:0]   mag_data,
  output logic [IDX_W-1:0]  mag_idx,
  output logic              frame_done,
  output logic [DATA_W:0]   peak_mag,
  output logic [IDX_W-1:0]  peak_idx,
  output logic              frame_err
);

  localparam int MAG_W = DATA_W + 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(FRAME_LEN - 1);

  // Frame state, as seen by the stage-2 (output) side of the pipeline
  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_active = 1'b1;

  // Bin counter
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // Stage 1: absolute values
  logic             s1_valid_q;
  logic [MAG_W-1:0] s1_re_q, s1_im_q;
  logic [IDX_W-1:0] s1_idx_q;

  // Stage 2: magnitude outputs
  logic             mag_valid_q;
  logic [MAG_W-1:0] mag_data_q;
  logic [IDX_W-1:0] mag_idx_q;

  // Peak tracking
  logic [MAG_W-1:0] run_mag_q, run_mag_d;
  logic [IDX_W-1:0] run_idx_q, run_idx_d;
  logic [MAG_W-1:0] peak_mag_q, peak_mag_d;
  logic [IDX_W-1:0] peak_idx_q, peak_idx_d;

  // Frame FSM
  logic [0:0] state_q, state_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_err_q, frame_err_d;

  // Combinational helpers
  logic [MAG_W-1:0] w_re_ext, w_im_ext, w_re_abs, w_im_abs, w_sum;
  logic             w_first, w_last, w_better;

  // Sign-extend by one bit before negating so abs(most-negative) is exact
  assign w_re_ext = {source_real[DATA_W-1], source_real};
  assign w_im_ext = {source_imag[DATA_W-1], source_imag};
  assign w_re_abs = source_real[DATA_W-1] ? (~w_re_ext + MAG_W'(1)) : w_re_ext;
  assign w_im_abs = source_imag[DATA_W-1] ? (~w_im_ext + MAG_W'(1)) : w_im_ext;

  // Each abs value is at most 2^(DATA_W-1), so the sum cannot overflow MAG_W
  assign w_sum    = s1_re_q + s1_im_q;
  assign w_first  = s1_valid_q && (s1_idx_q == '0);
  assign w_last   = s1_valid_q && (s1_idx_q == c_last_idx);
  // Bin 0 loads unconditionally; later bins need a strictly larger value
  assign w_better = s1_valid_q && (w_first || (w_sum > run_mag_q));

  // Bin counter next value: cleared whenever the stream is not valid
  always_comb begin
    cnt_d = cnt_q;
    if (!source_valid) begin
      cnt_d = '0;
    end else if (cnt_q == c_last_idx) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  // Bin counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Stage 1: capture abs values with the index the sample arrived with
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_idx_q   <= '0;
    end else begin
      s1_valid_q <= source_valid;
      s1_re_q    <= w_re_abs;
      s1_im_q    <= w_im_abs;
      s1_idx_q   <= cnt_q;
    end
  end

  // Stage 2: magnitude outputs, data/index hold while no valid bin arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      mag_valid_q <= 1'b0;
      mag_data_q  <= '0;
      mag_idx_q   <= '0;
    end else begin
      mag_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        mag_data_q <= w_sum;
        mag_idx_q  <= s1_idx_q;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        if (w_first) begin
          state_d = c_st_active;
        end
      end
      c_st_active: begin
        if (!s1_valid_q || w_last) begin
          state_d = c_st_idle;
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  // FSM outputs: completion and mid-frame drop pulses
  always_comb begin
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    if (state_q == c_st_active) begin
      frame_done_d = w_last;
      frame_err_d  = !s1_valid_q;
    end
  end

  // Running peak and published peak next values
  always_comb begin
    run_mag_d  = run_mag_q;
    run_idx_d  = run_idx_q;
    peak_mag_d = peak_mag_q;
    peak_idx_d = peak_idx_q;
    if (w_better) begin
      run_mag_d = w_sum;
      run_idx_d = s1_idx_q;
    end else if (frame_err_d) begin
      run_mag_d = '0;
      run_idx_d = '0;
    end
    // Publish including the last bin itself, in the same cycle as frame_done
    if (frame_done_d) begin
      peak_mag_d = w_better ? w_sum    : run_mag_q;
      peak_idx_d = w_better ? s1_idx_q : run_idx_q;
    end
  end

  // Peak and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      run_mag_q    <= '0;
      run_idx_q    <= '0;
      peak_mag_q   <= '0;
      peak_idx_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      run_mag_q    <= run_mag_d;
      run_idx_q    <= run_idx_d;
      peak_mag_q   <= peak_mag_d;
      peak_idx_q   <= peak_idx_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign mag_valid  = mag_valid_q;
  assign mag_data   = mag_data_q;
  assign mag_idx    = mag_idx_q;
  assign frame_done = frame_done_q;
  assign peak_mag   = peak_mag_q;
  assign peak_idx   = peak_idx_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_mag_peak.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_mag_peak
// Purpose  : Directed self-checking bench for fft_mag_peak.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_mag_peak;

  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 1024;
  localparam int IDX_W     = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              source_valid;
  logic [DATA_W-1:0] source_real;
  logic [DATA_W-1:0] source_imag;
  logic              mag_valid;
  logic [DATA_W:0]   mag_data;
  logic [IDX_W-1:0]  mag_idx;
  logic              frame_done;
  logic [DATA_W:0]   peak_mag;
  logic [IDX_W-1:0]  peak_idx;
  logic              frame_err;

  int n_checks    = 0;
  int n_errors    = 0;
  int n_done      = 0;
  int n_err_pulse = 0;

  always #5 clk = ~clk;

  fft_mag_peak #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .IDX_W     (IDX_W)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .source_valid (source_valid),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .mag_valid    (mag_valid),
    .mag_data     (mag_data),
    .mag_idx      (mag_idx),
    .frame_done   (frame_done),
    .peak_mag     (peak_mag),
    .peak_idx     (peak_idx),
    .frame_err    (frame_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock: inputs already set; sample outputs 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) n_done++;
    if (frame_err === 1'b1) n_err_pulse++;
  endtask

  // Stimulus patterns, magnitudes noted per case
  task automatic set_sample(input int mode, input int bin);
    int re;
    int im;
    re = 0;
    im = 0;
    case (mode)
      1: if (bin == 37) begin re = -128; im = 127; end             // 255 at 37
      2: begin
           if (bin == 5)        begin re = 50; im = 0;   end       // 50
           else if (bin == 900) begin re = 25; im = -25; end       // 50
           else                 begin re = -10; im = 0;  end       // 10
         end
      3: begin re = (bin == 1023) ? 100 : 1; im = 0; end            // 100 at 1023
      4: begin re = (bin == 0) ? 0 : 1; im = (bin == 0) ? -90 : 0; end // 90 at 0
      5: begin re = 3; im = -4; end                                 // 7
      6: begin re = -128; im = -128; end                            // 256
      default: begin re = 0; im = 0; end
    endcase
    source_real = 8'(re);
    source_imag = 8'(im);
  endtask

  task automatic idle_cycle();
    source_valid = 1'b0;
    set_sample(0, 0);
    tick();
  endtask

  initial begin
    reset        = 1'b1;
    source_valid = 1'b0;
    source_real  = '0;
    source_imag  = '0;
    repeat (3) tick();
    check_eq("rst_mag_valid",  32'(mag_valid),  0);
    check_eq("rst_mag_data",   32'(mag_data),   0);
    check_eq("rst_peak_mag",   32'(peak_mag),   0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    check_eq("rst_frame_err",  32'(frame_err),  0);
    reset = 1'b0;
    idle_cycle();
    idle_cycle();
    check_eq("idle_no_err", 32'(n_err_pulse), 0);

    // Single frame, one strong bin at 37 with abs(-128)
    source_valid = 1'b1;
    for (int b = 0; b < FRAME_LEN; b++) begin
      set_sample(1, b);
      tick();
      if (b == 0)  check_eq("lat_not_1", 32'(mag_valid), 0);
      if (b == 1) begin
        check_eq("lat2_valid", 32'(mag_valid), 1);
        check_eq("lat2_idx0",  32'(mag_idx),   0);
      end
      if (b == 38) begin
        check_eq("b37_data", 32'(mag_data), 255);
        check_eq("b37_idx",  32'(mag_idx),  37);
      end
      if (b == 1023) check_eq("f1_no_early_done", 32'(frame_done), 0);
    end
    idle_cycle();
    check_eq("f1_done",     32'(frame_done), 1);
    check_eq("f1_done_idx", 32'(mag_idx),    1023);
    check_eq("f1_peak_mag", 32'(peak_mag),   255);
    check_eq("f1_peak_idx", 32'(peak_idx),   37);
    idle_cycle();
    check_eq("f1_done_1cyc", 32'(frame_done), 0);
    check_eq("f1_bubble",    32'(mag_valid),  0);
    check_eq("f1_no_err",    32'(frame_err),  0);

    // Tie: 50 at bins 5 and 900, lowest index wins
    source_valid = 1'b1;
    for (int b = 0; b < FRAME_LEN; b++) begin
      set_sample(2, b);
      tick();
    end
    idle_cycle();
    check_eq("tie_done",     32'(frame_done), 1);
    check_eq("tie_peak_mag", 32'(peak_mag),   50);
    check_eq("tie_peak_idx", 32'(peak_idx),   5);
    idle_cycle();

    // Back-to-back frames: peak at 1023, then peak at 0
    source_valid = 1'b1;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      set_sample((i < FRAME_LEN) ? 3 : 4, i % FRAME_LEN);
      tick();
      if (i == FRAME_LEN) begin
        check_eq("b2b_done_a",     32'(frame_done), 1);
        check_eq("b2b_peak_idx_a", 32'(peak_idx),   1023);
        check_eq("b2b_peak_mag_a", 32'(peak_mag),   100);
      end
      if (i == FRAME_LEN + 1) begin
        check_eq("b2b_b0_valid", 32'(mag_valid),  1);
        check_eq("b2b_b0_idx",   32'(mag_idx),    0);
        check_eq("b2b_b0_data",  32'(mag_data),   90);
        check_eq("b2b_b0_nodone",32'(frame_done), 0);
      end
    end
    idle_cycle();
    check_eq("b2b_done_b",     32'(frame_done), 1);
    check_eq("b2b_peak_idx_b", 32'(peak_idx),   0);
    check_eq("b2b_peak_mag_b", 32'(peak_mag),   90);
    idle_cycle();

    // Drop source_valid after bin 499
    source_valid = 1'b1;
    for (int b = 0; b < 500; b++) begin
      set_sample(5, b);
      tick();
    end
    idle_cycle();
    check_eq("drop_last_idx", 32'(mag_idx),   499);
    check_eq("drop_err_early",32'(frame_err), 0);
    idle_cycle();
    check_eq("drop_err",       32'(frame_err),  1);
    check_eq("drop_no_done",   32'(frame_done), 0);
    check_eq("drop_bubble",    32'(mag_valid),  0);
    check_eq("drop_hold_idx",  32'(mag_idx),    499);
    check_eq("drop_hold_data", 32'(mag_data),   7);
    check_eq("drop_peak_mag",  32'(peak_mag),   90);
    check_eq("drop_peak_idx",  32'(peak_idx),   0);
    idle_cycle();
    check_eq("drop_err_1cyc", 32'(frame_err), 0);

    // Restart at bin 0, then reset while bin 600 is on the input
    source_valid = 1'b1;
    for (int b = 0; b < 600; b++) begin
      set_sample(5, b);
      tick();
      if (b == 1) begin
        check_eq("restart_idx",  32'(mag_idx),  0);
        check_eq("restart_data", 32'(mag_data), 7);
      end
    end
    set_sample(5, 600);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mrst_mag_valid",  32'(mag_valid),  0);
    check_eq("mrst_mag_data",   32'(mag_data),   0);
    check_eq("mrst_mag_idx",    32'(mag_idx),    0);
    check_eq("mrst_peak_mag",   32'(peak_mag),   0);
    check_eq("mrst_peak_idx",   32'(peak_idx),   0);
    check_eq("mrst_frame_done", 32'(frame_done), 0);
    check_eq("mrst_frame_err",  32'(frame_err),  0);
    repeat (3) idle_cycle();

    // Fresh frame with worst-case magnitude 256 on every bin
    source_valid = 1'b1;
    for (int b = 0; b < FRAME_LEN; b++) begin
      set_sample(6, b);
      tick();
      if (b == 1) begin
        check_eq("max_b0_data", 32'(mag_data), 256);
        check_eq("max_b0_idx",  32'(mag_idx),  0);
      end
      if (b == 513) begin
        check_eq("max_b512_data", 32'(mag_data), 256);
        check_eq("max_b512_idx",  32'(mag_idx),  512);
      end
    end
    idle_cycle();
    check_eq("max_done",     32'(frame_done), 1);
    check_eq("max_last_idx", 32'(mag_idx),    1023);
    check_eq("max_last_data",32'(mag_data),   256);
    check_eq("max_peak_mag", 32'(peak_mag),   256);
    check_eq("max_peak_idx", 32'(peak_idx),   0);
    idle_cycle();
    idle_cycle();

    check_eq("total_done_pulses", 32'(n_done),      5);
    check_eq("total_err_pulses",  32'(n_err_pulse), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
